// File: rtl/pkt_dequeue_engine_if.sv
// Signal bundle between the packet dequeue engine and its scheduler,
// free-list address manager, packet data RAM and output stream sink.
interface pkt_dequeue_engine_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 12
);
    logic                  s_desc_valid;
    logic                  s_desc_ready;
    logic [ADDR_WIDTH-1:0] s_desc_sop_addr;
    logic [LEN_WIDTH-1:0]  s_desc_len;
    logic                  addr_rd_en;
    logic                  addr_rd_first_word_en;
    logic [ADDR_WIDTH-1:0] addr_rd_pkt_sop_addr;
    logic [ADDR_WIDTH-1:0] addr_fl_tail_next;
    logic                  addr_is_empty;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  desc_err;

    modport master (
        input  s_desc_valid, s_desc_sop_addr, s_desc_len,
        input  addr_fl_tail_next, addr_is_empty,
        input  ram_rd_data, m_axis_tready,
        output s_desc_ready, addr_rd_en, addr_rd_first_word_en,
        output addr_rd_pkt_sop_addr, ram_rd_en, ram_rd_addr,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, desc_err
    );

    modport slave (
        output s_desc_valid, s_desc_sop_addr, s_desc_len,
        output addr_fl_tail_next, addr_is_empty,
        output ram_rd_data, m_axis_tready,
        input  s_desc_ready, addr_rd_en, addr_rd_first_word_en,
        input  addr_rd_pkt_sop_addr, ram_rd_en, ram_rd_addr,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, desc_err
    );
endinterface

// File: rtl/pkt_dequeue_engine.sv
// Walks a packet's word chain, frees words to the address manager and streams them out.
// Optional PKT_DEQ_STATS_EN adds stat_pkt_cnt / stat_word_cnt beat counters.
module pkt_dequeue_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    pkt_dequeue_engine_if.master bus
`ifdef PKT_DEQ_STATS_EN
    ,
    output logic [31:0] stat_pkt_cnt,
    output logic [31:0] stat_word_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] sop_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  first_q;
    logic                  inflight_q;
    logic                  last_q;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count_q;
    logic [PW+1:0]         occ;
    logic                  accept;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Occupancy counts the word already in flight from the RAM.
    assign occ    = {1'b0, count_q} + {{(PW+1){1'b0}}, inflight_q};
    assign accept = bus.s_desc_valid && bus.s_desc_ready;
    assign push   = inflight_q;
    assign pop    = bus.m_axis_tvalid && bus.m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q == IDLE:
                if (accept && bus.s_desc_len != '0) state_d = ISSUE;
            state_q == ISSUE:
                if (issue && rem_q == LEN_WIDTH'(1)) state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_desc_ready = 1'b0;
        bus.desc_err     = 1'b0;
        issue            = 1'b0;
        unique case (1'b1)
            state_q == IDLE: begin
                bus.s_desc_ready = !rst;
                bus.desc_err     = !rst && bus.s_desc_valid
                                   && bus.s_desc_len == '0;
            end
            state_q == ISSUE:
                issue = !rst && !bus.addr_is_empty
                        && occ < (PW+2)'(FIFO_DEPTH);
        endcase
        bus.addr_rd_en            = issue;
        bus.ram_rd_en             = issue;
        bus.addr_rd_first_word_en = issue && first_q;
        bus.ram_rd_addr           = '0;
        if (issue)
            bus.ram_rd_addr = first_q ? sop_q : bus.addr_fl_tail_next;
    end

    assign bus.addr_rd_pkt_sop_addr = sop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sop_q      <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            last_q     <= issue && rem_q == LEN_WIDTH'(1);
            if (accept && bus.s_desc_len != '0) begin
                sop_q   <= bus.s_desc_sop_addr;
                rem_q   <= bus.s_desc_len;
                first_q <= 1'b1;
            end else if (issue) begin
                rem_q   <= rem_q - LEN_WIDTH'(1);
                first_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {last_q, bus.ram_rd_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is masked so idle outputs read as zero.
    assign bus.m_axis_tvalid = count_q != '0;
    assign {bus.m_axis_tlast, bus.m_axis_tdata} =
        bus.m_axis_tvalid ? mem[rd_ptr] : '0;

`ifdef PKT_DEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_cnt  <= '0;
            stat_word_cnt <= '0;
        end else if (pop) begin
            stat_word_cnt <= stat_word_cnt + 32'd1;
            if (bus.m_axis_tlast) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: doc/pkt_dequeue_engine.md
# pkt_dequeue_engine

- Read-side counterpart of the free-list address manager in the PIFO packet buffer.
- Takes a packet descriptor (SOP address, length in words) from the scheduler and walks the packet's linked word chain.
- Drives the manager's read strobes so consumed words return to the free list, fetches each word from the packet data RAM, and emits the packet as an AXI4-Stream with backpressure.

## Interface
Parameters:
- ADDR_WIDTH, 12, buffer word address width (matches address manager)
- DATA_WIDTH, 64, packet data word width
- LEN_WIDTH, 12, descriptor length field width (words)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_desc_valid  in  1  descriptor valid
- s_desc_ready  out  1  descriptor accept; high only in IDLE
- s_desc_sop_addr  in  ADDR_WIDTH  first word address of packet
- s_desc_len  in  LEN_WIDTH  packet length in words
- addr_rd_en  out  1  to manager s_axis_rd_en: one word consumed
- addr_rd_first_word_en  out  1  to manager s_axis_rd_first_word_en
- addr_rd_pkt_sop_addr  out  ADDR_WIDTH  to manager s_axis_rd_pkt_sop_addr
- addr_fl_tail_next  in  ADDR_WIDTH  from manager m_axis_fl_tail_next (combinational)
- addr_is_empty  in  1  from manager m_axis_is_empty
- ram_rd_en  out  1  data RAM read enable
- ram_rd_addr  out  ADDR_WIDTH  data RAM read address
- ram_rd_data  in  DATA_WIDTH  data RAM output, valid 1 cycle after ram_rd_en
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  last word of packet
- desc_err  out  1  one-cycle pulse on dropped descriptor

## Operation
- States: IDLE, ISSUE.
- IDLE:
  - s_desc_ready=1.
  - On handshake with len≥1: latch sop and len into remaining counter, go ISSUE.
  - On handshake with len=0: drop it, pulse desc_err, stay IDLE; no manager/RAM activity.
- ISSUE: a word issues in a cycle when (fifo_count + inflight) < FIFO_DEPTH and addr_is_empty=0. inflight = ram_rd_en of the previous cycle.
- Issue cycle:
  - ram_rd_en=1, ram_rd_addr=addr_fl_tail_next, addr_rd_en=1.
  - First word of packet additionally drives addr_rd_first_word_en=1 and addr_rd_pkt_sop_addr=latched sop, so the tail links to the SOP and ram_rd_addr=sop.
  - Subsequent words follow the chain via addr_fl_tail_next.
  - Remaining counter decrements. The word issued with remaining=1 is tagged last; the FSM then returns to IDLE.
- Non-issue cycles: addr_rd_en, addr_rd_first_word_en, ram_rd_en all 0. addr_rd_pkt_sop_addr holds the latched sop.
- Data path:
  - RAM data plus last tag are written into the FIFO one cycle after issue.
  - FIFO head drives m_axis_*.
  - Pop on tvalid&tready.
  - tdata and tlast stay stable while tvalid=1 and tready=0.
- Counters and widths:
  - fifo_count is log2(FIFO_DEPTH)+1 bits.
  - Remaining counter is LEN_WIDTH bits and never wraps; it is only decremented from ≥1.
- Simultaneous FIFO push and pop: count unchanged.
- Empty guard: addr_is_empty=1 in ISSUE stalls issue. The packet resumes where it stopped; no word is skipped.

## Timing
- Reset values: s_desc_ready=0 during rst, 1 in the first cycle after. All other outputs 0, including m_axis_tvalid, tlast, tdata, addr_rd_pkt_sop_addr, desc_err.
- Latency:
  - Descriptor accepted at T → first issue at T+1 → FIFO write at T+2 → m_axis_tvalid=1 at T+3.
- Throughput: one word per cycle while tready=1.
- Packet gap: one issue bubble between back-to-back packets (IDLE cycle).
- Backpressure: issue stops once occupancy + inflight reaches FIFO_DEPTH, so the FIFO never overflows. No combinational path from m_axis_tready to the issue logic.
- Reset mid-packet:
  - FSM → IDLE, FIFO flushed, counters cleared.
  - No partial packet tail is emitted after reset.
  - The address manager is reset in the same cycle.

## Configuration
- PKT_DEQ_STATS_EN defined: adds outputs stat_pkt_cnt[31:0] (+1 per tlast beat accepted) and stat_word_cnt[31:0] (+1 per accepted beat). Both are wrapping and cleared by rst.
- PKT_DEQ_STATS_EN not defined: those ports are absent and no counter logic is synthesized.

## Test plan
- Single 1-word packet, sop=0x005, len=1, tready=1 → issue at T+1 with first_word_en=1, rd_en=1, ram_rd_addr=0x005; one beat tvalid at T+3 with tlast=1.
- 4-word chain 0x010→0x020→0x030→0x040, tready=1 → ram_rd_addr sequence 0x010,0x020,0x030,0x040 on consecutive cycles; 4 beats; tlast only on the 4th; rd_en asserted exactly 4 times.
- Same 4-word packet with tready=0 from T+2 to T+10 → issues stop after FIFO_DEPTH words; data stable; all 4 words delivered in order after release; no loss or duplication.
- Two back-to-back descriptors (len 3, len 2) → 5 beats; tlast on beats 3 and 5; exactly one idle issue cycle between packets.
- Descriptor len=0 → desc_err pulses one cycle; no rd_en, ram_rd_en or tvalid; next descriptor is accepted the following cycle.
- rst asserted mid-packet after 2 of 6 words → tvalid=0 the next cycle; s_desc_ready=1 after rst deasserts; a new 1-word packet completes normally.
